// File: rtl/piso_stream.sv
// Purpose : parallel-in serial-out shifter with one-word hold buffer for gapless streaming.
// Latency : first bit valid 1 cycle after a word is accepted; frame_done 1 cycle after last bit.
// Backpr. : sout_ready=0 freezes sout/shift/counter; load_ready drops while the hold buffer is full.
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   pin, load_valid/load_ready - parallel word input handshake
//   sout, sout_valid/sout_ready - serial bit output handshake
//   frame_done                 - one-cycle pulse after the last bit of a word is consumed
//   busy                       - a word is shifting or waiting in the hold buffer
module piso_stream #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] shift_q,      shift_d;
    logic [WIDTH-1:0] hold_q,       hold_d;
    logic             hold_full_q,  hold_full_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic             frame_done_q, frame_done_d;

    logic             load_acc;
    logic             bit_acc;
    logic             last_bit;
    logic [WIDTH-1:0] shifted;

    // The hold buffer is the only place a word can wait, so readiness is just its emptiness.
    assign load_ready = ~hold_full_q;
    assign load_acc   = load_valid & load_ready;
    assign bit_acc    = (state_q == ST_SHIFT) & sout_ready;
    assign last_bit   = (cnt_q == CNT_LAST);

    // Shift toward the output end, zero-filling the vacated bit.
    assign shifted = LSB_FIRST ? {1'b0, shift_q[WIDTH-1:1]}
                               : {shift_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_acc) begin
                    shift_d = pin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (bit_acc && last_bit) begin
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
                    if (hold_full_q) begin
                        // Held word follows immediately; load_acc cannot be set here.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (load_acc) begin
                        // Word arriving exactly on the last bit bypasses the hold buffer.
                        shift_d = pin;
                    end else begin
                        shift_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (bit_acc) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + CW'(1);
                    end
                    if (load_acc) begin
                        hold_d      = pin;
                        hold_full_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Outputs are decoded straight from registered state, so they are glitch-free.
    assign sout_valid = (state_q == ST_SHIFT);
    assign sout       = (state_q == ST_SHIFT) ?
                        (LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1]) : 1'b0;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == ST_SHIFT) | hold_full_q;

endmodule

// File: tb/tb_piso_stream.sv
// Purpose : directed bench for piso_stream, MSB-first and LSB-first instances side by side.
// Latency : expected bits queued on load acceptance, compared when each bit is presented.
// Backpr. : sout_ready is driven by the stimulus; both instances see identical inputs.
module tb_piso_stream;

    typedef struct {
        logic b;
        logic last;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pin = 8'h00;
    logic       load_valid = 1'b0;
    logic       sout_ready = 1'b1;

    logic lr0, s0, sv0, fd0, b0;
    logic lr1, s1, sv1, fd1, b1;

    ent_t q0[$];
    ent_t q1[$];

    int checks = 0;
    int errors = 0;
    bit last_acc = 1'b0;

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin        (pin),
        .load_valid (load_valid),
        .load_ready (lr0),
        .sout       (s0),
        .sout_valid (sv0),
        .sout_ready (sout_ready),
        .frame_done (fd0),
        .busy       (b0)
    );

    piso_stream #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin        (pin),
        .load_valid (load_valid),
        .load_ready (lr1),
        .sout       (s1),
        .sout_valid (sv1),
        .sout_ready (sout_ready),
        .frame_done (fd1),
        .busy       (b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            q0.push_back('{b: w[7-i], last: (i == 7)});
            q1.push_back('{b: w[i],   last: (i == 7)});
        end
    endtask

    // Check all outputs against the model, then advance one clock edge.
    task automatic tick();
        bit fd_e0;
        bit fd_e1;
        bit rdy_e;
        fd_e0 = 1'b0;
        fd_e1 = 1'b0;
        // More than one word's bits outstanding means a word sits in the hold buffer.
        rdy_e = (q0.size() <= 8);
        last_acc = 1'b0;
        chk("load_ready_msb", lr0, rdy_e);
        chk("load_ready_lsb", lr1, rdy_e);
        chk("sout_valid_msb", sv0, q0.size() != 0);
        chk("sout_valid_lsb", sv1, q1.size() != 0);
        chk("busy_msb", b0, q0.size() != 0);
        chk("busy_lsb", b1, q1.size() != 0);
        if (q0.size() != 0) chk("sout_msb", s0, q0[0].b);
        else                chk("sout_idle_msb", s0, 0);
        if (q1.size() != 0) chk("sout_lsb", s1, q1[0].b);
        else                chk("sout_idle_lsb", s1, 0);
        if (q0.size() != 0 && sout_ready) begin
            fd_e0 = q0[0].last;
            void'(q0.pop_front());
        end
        if (q1.size() != 0 && sout_ready) begin
            fd_e1 = q1[0].last;
            void'(q1.pop_front());
        end
        if (load_valid && rdy_e) begin
            push_word(pin);
            last_acc = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("frame_done_msb", fd0, fd_e0);
        chk("frame_done_lsb", fd1, fd_e1);
    endtask

    task automatic offer(input logic [7:0] w);
        load_valid = 1'b1;
        pin = w;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("offer_accepted", last_acc, 1);
        load_valid = 1'b0;
        pin = 8'h00;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (q0.size() == 0) break;
            tick();
        end
        chk("drained", q0.size(), 0);
        tick();
    endtask

    task automatic rst_checks();
        chk("rst_sout_msb", s0, 0);
        chk("rst_sout_valid_msb", sv0, 0);
        chk("rst_frame_done_msb", fd0, 0);
        chk("rst_busy_msb", b0, 0);
        chk("rst_load_ready_msb", lr0, 1);
        chk("rst_sout_valid_lsb", sv1, 0);
        chk("rst_busy_lsb", b1, 0);
        chk("rst_load_ready_lsb", lr1, 1);
    endtask

    initial begin
        // Reset with a word offered: nothing may be captured.
        rst_n = 1'b0;
        load_valid = 1'b1;
        pin = 8'h55;
        #1;
        rst_checks();
        @(posedge clk); #1;
        rst_checks();
        @(posedge clk); #1;
        rst_checks();
        load_valid = 1'b0;
        rst_n = 1'b1;

        // 0xA5 accepted on the first edge after reset release.
        load_valid = 1'b1;
        pin = 8'hA5;
        tick();
        chk("accept_after_reset", last_acc, 1);
        load_valid = 1'b0;
        drain();

        // 0x1E: MSB-first 00011110, LSB-first 01111000.
        offer(8'h1E);
        drain();

        // Back-to-back with hold buffer, plus a third word stalled while hold is full.
        offer(8'hF0);
        offer(8'h0F);
        chk("hold_full_blocks_load", lr0, 0);
        offer(8'h3C);
        drain();

        // Word offered exactly on the last bit loads directly, no gap.
        offer(8'hC3);
        repeat (7) tick();
        offer(8'h5A);
        drain();

        // Backpressure after two bits: sout holds bit 2 of 0xA5.
        offer(8'hA5);
        tick();
        tick();
        sout_ready = 1'b0;
        repeat (3) tick();
        chk("stall_sout_msb", s0, 1);
        sout_ready = 1'b1;
        drain();

        // Reset mid-frame with 0x3C held, then 0x81.
        offer(8'hA5);
        offer(8'h3C);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        rst_checks();
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        rst_checks();
        rst_n = 1'b1;
        load_valid = 1'b1;
        pin = 8'h81;
        tick();
        chk("accept_after_mid_reset", last_acc, 1);
        load_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Parameters
REQ-001 WIDTH, 8, parallel word width in bits; legal range 2..32.
REQ-002 LSB_FIRST, 0, serial bit order: 0 = MSB first, 1 = LSB first.

Interface
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pin  input  WIDTH  parallel word to serialise.
REQ-006 load_valid  input  1  pin holds a word for transfer.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  current serial bit.
REQ-009 sout_valid  output  1  sout carries a valid bit.
REQ-010 sout_ready  input  1  downstream consumes sout this cycle.
REQ-011 frame_done  output  1  one-cycle pulse after the last bit of a word is consumed.
REQ-012 busy  output  1  a word is shifting or waiting in the hold buffer.

Function
REQ-013 Load handshake: a word is accepted on a rising edge where load_valid and load_ready are both 1.
REQ-014 Bit handshake: a bit is consumed on a rising edge where sout_valid and sout_ready are both 1.
REQ-015 Storage: shift register (WIDTH), bit counter (0..WIDTH-1), one-word hold buffer with a full flag, and a state machine with states IDLE and SHIFT.
REQ-016 load_ready SHALL equal NOT hold-full; it is combinational.
REQ-017 IDLE, word accepted: load the word into the shift register, clear the counter, go to SHIFT; sout_valid is 1 in the following cycle (latency 1).
REQ-018 SHIFT, word accepted: write the word into the hold buffer and set hold-full.
REQ-019 SHIFT: sout = shift-register bit WIDTH-1 when LSB_FIRST=0, bit 0 when LSB_FIRST=1; sout_valid = 1.
REQ-020 IDLE: sout = 0 and sout_valid = 0.
REQ-021 Non-last bit consumed: shift by one toward the output end, fill the vacated bit with 0, increment the counter.
REQ-022 Last bit consumed (counter = WIDTH-1) with hold-full set: move the hold word into the shift register, clear hold-full and the counter, stay in SHIFT. There is no idle cycle between words.
REQ-023 Last bit consumed with hold-full clear and a word accepted in the same cycle: load that word directly into the shift register and stay in SHIFT.
REQ-024 Last bit consumed with no word pending: go to IDLE.
REQ-025 frame_done is registered and is 1 for exactly one cycle following every last-bit consumption.
REQ-026 sout_ready=0 in SHIFT: hold sout, the shift register and the counter; there is no data loss.
REQ-027 A load offered while hold-full is set is not accepted; load_valid then stays asserted with pin stable until accepted.
REQ-028 busy = (state is SHIFT) OR hold-full.

Reset
REQ-029 While rst_n=0: state IDLE; shift register, hold buffer, counter and hold-full all 0.
REQ-030 Outputs while rst_n=0: sout=0, sout_valid=0, frame_done=0, busy=0, load_ready=1. No word is captured while rst_n is low.
REQ-031 Reset asserted mid-frame discards both the shifting word and the held word; frame_done does not pulse for them.
REQ-032 After rst_n deasserts, the first rising edge can accept a word.

Verification (WIDTH=8)
REQ-033 LSB_FIRST=0, pin=0xA5 accepted, sout_ready=1 -> sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then frame_done for 1 cycle, then IDLE.
REQ-034 LSB_FIRST=1, pin=0x1E -> sout = 0,1,1,1,1,0,0,0, then frame_done.
REQ-035 Back-to-back: 0xF0 then 0x0F, second word offered during the first -> 16 contiguous valid bits 11110000 00001111, two frame_done pulses 8 cycles apart, load_ready=0 while the hold buffer is full.
REQ-036 Backpressure: 0xA5 with sout_ready=0 for 3 cycles after bit 2 -> sout holds 1 and the counter is frozen; the full sequence resumes unchanged.
REQ-037 Reset after bit 4 of 0xA5 with 0x3C held -> sout_valid=0, busy=0, no frame_done; a new 0x81 loads on the next edge and serialises as 1,0,0,0,0,0,0,1.
